// File: rtl/eep_spi_resp.sv
// SPI mode-0 responder fronting a 64x8 calibration store. Takes 16-bit command frames.
// Read data is returned full-duplex on the frame that follows the command.
module eep_spi_resp #(
  parameter logic [7:0] INIT_VAL = 8'h80
) (
  input  logic clk,
  input  logic rst,
  input  logic SCLK,
  input  logic MOSI,
  input  logic SS_n,
  input  logic wp,
  output logic MISO,
  output logic xfer_done,
  output logic xfer_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, ABORT} state_t;

  // The synchronizers are not reset, so they keep tracking the pins while rst is
  // high. If SS_n is held low through reset, no fall is seen when rst releases.
  logic [2:0] sclk_q, ss_q;
  logic [1:0] mosi_q;

  always_ff @(posedge clk) begin
    sclk_q <= {sclk_q[1:0], SCLK};
    ss_q   <= {ss_q[1:0], SS_n};
    mosi_q <= {mosi_q[0], MOSI};
  end

  logic sclk_rise, sclk_fall, ss_fall, ss_rise;
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign ss_fall   = ~ss_q[1] & ss_q[2];
  assign ss_rise   = ss_q[1] & ~ss_q[2];

  state_t      state;
  logic [15:0] rx_shift, tx_shift, resp;
  logic [4:0]  bit_cnt;
  logic        pend;
  logic [7:0]  store [64];

  logic [1:0]  op;
  logic [5:0]  addr;
  logic [7:0]  data;
  assign op   = rx_shift[15:14];
  assign addr = rx_shift[13:8];
  assign data = rx_shift[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rx_shift  <= '0;
      tx_shift  <= '0;
      resp      <= '0;
      bit_cnt   <= '0;
      pend      <= 1'b0;
      MISO      <= 1'b0;
      xfer_done <= 1'b0;
      xfer_err  <= 1'b0;
      for (int i = 0; i < 64; i++) store[i] <= INIT_VAL;
    end else begin
      xfer_done <= 1'b0;
      xfer_err  <= 1'b0;
      MISO      <= (state == SHIFT) & tx_shift[15];
      case (state)
        IDLE: begin
          if (ss_fall || pend) begin
            tx_shift <= resp;
            bit_cnt  <= '0;
            pend     <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // ss_rise wins over any SCLK edge in the same clk
          if (ss_rise) begin
            state <= (bit_cnt == 5'd16) ? COMMIT : ABORT;
          end else begin
            if (sclk_rise && bit_cnt < 5'd16) begin
              rx_shift <= {rx_shift[14:0], mosi_q[1]};
              bit_cnt  <= bit_cnt + 5'd1;
            end
            if (sclk_fall && bit_cnt >= 5'd1 && bit_cnt < 5'd16)
              tx_shift <= {tx_shift[14:0], 1'b0};
          end
        end
        COMMIT: begin
          xfer_done <= 1'b1;
          pend      <= ss_fall;
          state     <= IDLE;
          case (op)
            2'b00: resp <= {2'b00, addr, store[addr]};
            2'b01: begin
              if (wp) begin
                resp     <= {2'b10, addr, 8'h00};
                xfer_err <= 1'b1;
              end else begin
                store[addr] <= data;
                resp        <= {2'b01, addr, data};
              end
            end
            default: resp <= {2'b11, 14'h0};
          endcase
        end
        default: begin
          resp     <= '0;
          xfer_err <= 1'b1;
          pend     <= ss_fall;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eep_spi_resp.sv
// Bench for eep_spi_resp: a mode-0 SPI master task plus a frame-level reference model.
// Expected MISO words and pulses are queued, and separate monitors check them.
module tb_eep_spi_resp;
  logic clk = 1'b0;
  logic rst, SCLK, MOSI, SS_n, wp;
  logic MISO, xfer_done, xfer_err;

  eep_spi_resp #(.INIT_VAL(8'h80)) dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .MOSI(MOSI), .SS_n(SS_n), .wp(wp),
    .MISO(MISO), .xfer_done(xfer_done), .xfer_err(xfer_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_miso [$];
  logic [15:0] got_q    [$];
  logic [1:0]  exp_evt  [$];   // {done, err}

  // frame-level reference model
  logic [7:0]  mem_m [64];
  logic [15:0] resp_m;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mem_m[i] = 8'h80;
    resp_m = 16'h0000;
  endtask

  task automatic model(input logic [15:0] cmd, input int nbits, input bit wpv);
    logic [5:0] a;
    logic [7:0] d;
    a = cmd[13:8];
    d = cmd[7:0];
    if (nbits >= 16) exp_miso.push_back(resp_m);
    if (nbits < 16) begin
      resp_m = 16'h0000;
      exp_evt.push_back(2'b01);
    end else if (cmd[15]) begin
      resp_m = 16'hC000;
      exp_evt.push_back(2'b10);
    end else if (!cmd[14]) begin
      resp_m = {2'b00, a, mem_m[a]};
      exp_evt.push_back(2'b10);
    end else if (wpv) begin
      resp_m = {2'b10, a, 8'h00};
      exp_evt.push_back(2'b11);
    end else begin
      mem_m[a] = d;
      resp_m = {2'b01, a, d};
      exp_evt.push_back(2'b10);
    end
  endtask

  // One SS_n cycle with nbits SCLK pulses; returns the first 16 MISO bits.
  task automatic frame(input logic [15:0] cmd, input int nbits, input bit wpv,
                       output logic [15:0] got);
    model(cmd, nbits, wpv);
    got = 16'h0;
    @(negedge clk);
    wp   = wpv;
    SS_n = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      MOSI = (i < 16) ? cmd[15-i] : 1'($urandom);
      repeat (8) @(negedge clk);
      if (i < 16) got[15-i] = MISO;
      SCLK = 1'b1;
      repeat (8) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (8) @(negedge clk);
    SS_n = 1'b1;
    if (nbits >= 16) got_q.push_back(got);
    repeat (12) @(negedge clk);
    wp = 1'b0;
  endtask

  // rst pulse after 8 bits of a write; SS_n stays low through reset release.
  task automatic reset_mid_frame(input logic [15:0] cmd);
    @(negedge clk);
    SS_n = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      MOSI = cmd[15-i];
      repeat (8) @(negedge clk);
      SCLK = 1'b1;
      repeat (8) @(negedge clk);
      SCLK = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (10) @(negedge clk);
    chk("miso_idle_after_rst", {15'h0, MISO}, 16'h0);
    SS_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  // pulse monitor: every pulse must match the next expected event
  always @(negedge clk) begin
    if (!rst && (xfer_done || xfer_err)) begin
      if (exp_evt.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse got done=%0b err=%0b exp=none", xfer_done, xfer_err);
      end else begin
        chk("pulse", {14'h0, xfer_done, xfer_err}, {14'h0, exp_evt.pop_front()});
      end
    end
  end

  // MISO word monitor
  always @(negedge clk) begin
    if (got_q.size() > 0) begin
      if (exp_miso.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_miso_word got=%h exp=none", got_q.pop_front());
      end else begin
        chk("miso_word", got_q.pop_front(), exp_miso.pop_front());
      end
    end
  end

  initial begin
    logic [15:0] g, cmd;
    int nb;
    bit w;
    rst = 1'b1; SCLK = 1'b0; MOSI = 1'b0; SS_n = 1'b1; wp = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    chk("reset_outs", {13'h0, MISO, xfer_done, xfer_err}, 16'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_outs", {13'h0, MISO, xfer_done, xfer_err}, 16'h0);

    frame(16'h0500, 16, 0, g);
    frame(16'h0000, 16, 0, g);
    chk("read_init", g, 16'h0580);

    frame(16'h4A3C, 16, 0, g);
    frame(16'h0A00, 16, 0, g);
    chk("write_resp", g, 16'h4A3C);
    frame(16'h0000, 16, 0, g);
    chk("write_readback", g, 16'h0A3C);

    frame(16'h4A55, 16, 1, g);
    frame(16'h0A00, 16, 0, g);
    chk("wp_resp", g, 16'h8A00);
    frame(16'h0000, 16, 0, g);
    chk("wp_unchanged", g, 16'h0A3C);

    frame(16'h4B11, 9, 0, g);
    frame(16'h0B00, 16, 0, g);
    chk("abort_resp", g, 16'h0000);
    frame(16'h0000, 16, 0, g);
    chk("abort_nowrite", g, 16'h0B80);

    frame(16'h4C77, 20, 0, g);
    frame(16'h0C00, 16, 0, g);
    chk("overlong_resp", g, 16'h4C77);
    frame(16'h0000, 16, 0, g);
    chk("overlong_store", g, 16'h0C77);

    frame(16'hC123, 16, 0, g);
    frame(16'h0000, 16, 0, g);
    chk("reserved_resp", g, 16'hC000);

    reset_mid_frame(16'h4D99);
    frame(16'h0D00, 16, 0, g);
    chk("rst_mid_resp", g, 16'h0000);
    frame(16'h0000, 16, 0, g);
    chk("rst_mid_store", g, 16'h0D80);

    for (int k = 0; k < 40; k++) begin
      cmd = 16'($urandom);
      if (k % 3 == 0) cmd[15:14] = 2'b01;
      case ($urandom_range(9))
        0:       nb = $urandom_range(15);
        1:       nb = $urandom_range(20, 17);
        default: nb = 16;
      endcase
      w = ($urandom_range(3) == 0);
      frame(cmd, nb, w, g);
    end

    repeat (20) @(negedge clk);
    chk("evt_drained", 16'(exp_evt.size()), 16'h0);
    chk("miso_drained", 16'(exp_miso.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
